// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Step counter must hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Accumulator / multiplicand / multiplier registers and the adder of the shift-and-add multiplier.
// Macro SEQ_MULT_EARLY_TERM_EN adds a "remaining multiplier bits are zero" flag.
module seq_mult_datapath #(
    parameter int WIDTH = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] sum_o
`ifdef SEQ_MULT_EARLY_TERM_EN
    ,
    output logic               mplier_zero_o
`endif
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    mcand_d;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] mplier_d;
    logic [PW-1:0]    addend_s;

    // Partial-product add; sum_o is also the value p takes on the final step.
    always_comb begin
        addend_s = mplier_q[0] ? mcand_q : {PW{1'b0}};
        sum_o    = acc_q + addend_s;
    end

`ifdef SEQ_MULT_EARLY_TERM_EN
    // Zero once shifted means no further partial product can contribute.
    always_comb begin
        mplier_zero_o = (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
    end
`endif

    // Next-state selection: load a fresh operation, advance one bit, or hold.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            acc_d    = {PW{1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
        end else if (step_i) begin
            acc_d    = sum_o;
            mcand_d  = {mcand_q[PW-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        end else begin
            acc_d    = acc_q;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= {PW{1'b0}};
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned radix-2 shift-and-add multiplier with start/busy/done handshake.
// Define SEQ_MULT_EARLY_TERM_EN to finish as soon as no multiplier bits remain.
module seq_shift_add_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    mult_state_t        state_q;
    mult_state_t        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2*WIDTH-1:0] p_q;
    logic [2*WIDTH-1:0] p_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;
    logic               load_s;
    logic               step_s;
    logic               last_s;
    logic [2*WIDTH-1:0] sum_s;
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic               mplier_zero_s;
`endif

    seq_mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk_i         (clk),
        .rst_i         (rst),
        .load_i        (load_s),
        .step_i        (step_s),
        .a_i           (a),
        .b_i           (b),
        .sum_o         (sum_s)
`ifdef SEQ_MULT_EARLY_TERM_EN
        ,
        .mplier_zero_o (mplier_zero_s)
`endif
    );

    // Final step of an operation.
    always_comb begin
`ifdef SEQ_MULT_EARLY_TERM_EN
        last_s = (cnt_q == CNT_W'(1)) || mplier_zero_s;
`else
        last_s = (cnt_q == CNT_W'(1));
`endif
    end

    // FSM next state, counter, product capture and datapath enables.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (last_s) begin
                    p_d     = sum_s;
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            p_q     <= {(2*WIDTH){1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: doc/seq_shift_add_mult.md
Name: seq_shift_add_mult

Overview:
- Parametrised sequential unsigned multiplier; the successor to the team's fixed 3x3 gate-level array multiplier.
- Computes p = a * b for WIDTH-bit operands using radix-2 shift-and-add, one multiplier bit per clock.
- Uses a start/busy/done handshake so an upstream controller can issue back-to-back operations.
- Trades the array's area for latency; sits in the arithmetic datapath wherever a multi-cycle product is acceptable.

Parameters:
- WIDTH, 3, operand width in bits (legal 2..32); product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), width of the step counter (derived; not user-overridden).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when busy=0.
- a  input  WIDTH  multiplicand (unsigned); captured on accepted start.
- b  input  WIDTH  multiplier (unsigned); captured on accepted start.
- busy  output  1  high while an operation is in progress (state RUN).
- done  output  1  one-cycle pulse; p is valid in that cycle.
- p  output  2*WIDTH  product; holds its value until the next accepted start.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, p=0, internal accumulator/shift/counter registers=0. Reset overrides everything, including an operation mid-RUN; the partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> latch mcand=a (zero-extended to 2*WIDTH), mplier=b, acc=0, cnt=WIDTH; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1), each edge:
  - If mplier[0]=1, acc = acc + mcand, with modulo 2^(2*WIDTH); no overflow is possible for unsigned operands.
  - mcand shifts left by 1; mplier shifts right by 1; cnt decrements by 1.
  - When cnt reaches 1 on this edge, this is the last step: write the final acc to p and go to DONE.
  - start is ignored while busy=1 (no queueing).
- DONE (done=1, busy=0, lasts exactly one cycle):
  - start=1 is accepted exactly as in IDLE, so back-to-back operations are possible; p keeps the old result until the new operation's DONE.
  - With start=0, go to IDLE.
- Latency: done is high in the cycle after WIDTH+1 rising edges counted from the edge that sampled start. Throughput: one result per WIDTH+1 cycles.
- p changes only on the edge that enters DONE, or on reset.
- Operand changes on a or b after the start edge have no effect.
- Width rules: all arithmetic is unsigned, 2*WIDTH bits wide; no truncation of the product.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In RUN, if the post-shift mplier equals 0, finish immediately: write acc to p and go to DONE.
  - Latency = (index of the highest set bit of b) + 2 edges; b=0 takes 2 edges.
  - p must be identical to the non-early-terminating result.
- Undefined: fixed latency of WIDTH+1 edges, as specified above.

Decomposition:
- Package seq_mult_pkg holds:
  - typedef enum mult_state_t {IDLE, RUN, DONE};
  - helper function for CNT_W.
- One natural sub-module: seq_mult_datapath.
  - Contains the acc, mcand and mplier registers and the adder, controlled by load/step enables.
  - The top level keeps the FSM and the counter.

Test Plan:
- WIDTH=3, a=7, b=7, single start pulse -> busy high for 3 cycles; done pulses once after 4 edges; p=49.
- WIDTH=3, sweep all 64 (a,b) pairs back-to-back, with start asserted in each DONE cycle -> every p matches a*b; one done every 4 cycles.
- WIDTH=3, a=5, b=3; start re-asserted with a=1, b=1 during RUN -> second request ignored; p=15.
- WIDTH=8, a=255, b=255 -> p=65025 after 9 edges; then rst asserted 4 edges into a new 200*3 operation -> busy=0, done=0, p=0 next cycle; no done follows.
- WIDTH=3, a=0, b=5 and a=6, b=0 -> p=0 with done pulsed normally; p unchanged while idle between operations.
- SEQ_MULT_EARLY_TERM_EN, WIDTH=8: a=9, b=1 -> done after 2 edges, p=9. a=3, b=0x80 -> done after 9 edges, p=384.
